// File: rtl/pico_intr_ctrl.sv
// pico_intr_ctrl: interrupt controller for the PICO basic system.
//
// Latches rising edges of the peripheral IRQ lines into pending bits and gates
// them with a mask register and the global interrupt enable (IE). The lowest
// eligible index is granted, and the request/acknowledge/RETI handshake with
// the core runs through a three-state FSM.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   irq_in     in   [NIRQ] interrupt sources, rising-edge sensitive
//   mask_we    in   mask register write enable
//   mask_din   in   [NIRQ] new mask value, 1 = source enabled
//   ie_set     in   set IE (EI)
//   ie_clr     in   clear IE (DI), wins over ie_set
//   int_ack    in   CPU accepts the current request (REQ only)
//   reti       in   CPU leaves the handler (SERVICE only)
//   int_req    out  interrupt request to the CPU
//   int_id     out  [IDW] index of the requested source
//   ie         out  global interrupt enable flag
//   pending    out  [NIRQ] pending bits
//   mask       out  [NIRQ] mask register
//   in_service out  handler running
module pico_intr_ctrl #(
   parameter int unsigned NIRQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq_in,
   input  logic            mask_we,
   input  logic [NIRQ-1:0] mask_din,
   input  logic            ie_set,
   input  logic            ie_clr,
   input  logic            int_ack,
   input  logic            reti,
   output logic            int_req,
   output logic [IDW-1:0]  int_id,
   output logic            ie,
   output logic [NIRQ-1:0] pending,
   output logic [NIRQ-1:0] mask,
   output logic            in_service
);

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e          state_q, state_d;
   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] pending_q, pending_d;
   logic [NIRQ-1:0] mask_q, mask_d;
   logic            ie_q, ie_d;
   logic            int_req_q, int_req_d;
   logic [IDW-1:0]  int_id_q, int_id_d;
   logic            in_service_q, in_service_d;

   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] eligible;
   logic [NIRQ-1:0] ack_clr;
   logic [IDW-1:0]  sel_id;
   logic            do_ack;
   logic            do_reti;

   assign rise     = irq_in & ~irq_q;
   assign eligible = pending_q & mask_q;
   assign do_ack   = (state_q == StReq) && int_ack;
   assign do_reti  = (state_q == StService) && reti;

   // Fixed priority: scan downwards so the lowest set index is left in sel_id.
   always_comb begin
      sel_id = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_id = IDW'(i);
         end
      end
   end

   // One-hot of the granted source, used to retire its pending bit on ack.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < int'(NIRQ); i++) begin
         if (do_ack && (int_id_q == IDW'(i))) begin
            ack_clr[i] = 1'b1;
         end
      end
   end

   // A fresh edge on the source being acknowledged keeps its pending bit set.
   assign pending_d = (pending_q & ~ack_clr) | rise;
   assign mask_d    = mask_we ? mask_din : mask_q;

   // Software EI/DI first, then hardware ack/RETI override it.
   always_comb begin
      ie_d = ie_q;
      if (ie_clr) begin
         ie_d = 1'b0;
      end else if (ie_set) begin
         ie_d = 1'b1;
      end
      if (do_ack) begin
         ie_d = 1'b0;
      end else if (do_reti) begin
         ie_d = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      int_req_d    = int_req_q;
      int_id_d     = int_id_q;
      in_service_d = in_service_q;
      unique case (state_q)
         StIdle: begin
            if (ie_q && (eligible != '0)) begin
               int_id_d  = sel_id;
               int_req_d = 1'b1;
               state_d   = StReq;
            end
         end
         StReq: begin
            // Grant is committed; only the ack moves on from here.
            if (int_ack) begin
               int_req_d    = 1'b0;
               in_service_d = 1'b1;
               state_d      = StService;
            end
         end
         StService: begin
            if (reti) begin
               in_service_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: begin
            state_d      = StIdle;
            int_req_d    = 1'b0;
            in_service_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         irq_q        <= '0;
         pending_q    <= '0;
         mask_q       <= '0;
         ie_q         <= 1'b0;
         int_req_q    <= 1'b0;
         int_id_q     <= '0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq_in;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         ie_q         <= ie_d;
         int_req_q    <= int_req_d;
         int_id_q     <= int_id_d;
         in_service_q <= in_service_d;
      end
   end

   assign int_req    = int_req_q;
   assign int_id     = int_id_q;
   assign ie         = ie_q;
   assign pending    = pending_q;
   assign mask       = mask_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_pico_intr_ctrl.sv
// Directed testbench for pico_intr_ctrl with hand-computed expectations.
module tb_pico_intr_ctrl;

   localparam int unsigned NIRQ = 4;
   localparam int unsigned IDW  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NIRQ-1:0] irq_in = '0;
   logic            mask_we = 1'b0;
   logic [NIRQ-1:0] mask_din = '0;
   logic            ie_set = 1'b0;
   logic            ie_clr = 1'b0;
   logic            int_ack = 1'b0;
   logic            reti = 1'b0;
   logic            int_req;
   logic [IDW-1:0]  int_id;
   logic            ie;
   logic [NIRQ-1:0] pending;
   logic [NIRQ-1:0] mask;
   logic            in_service;

   int n_vec = 0;
   int n_err = 0;

   pico_intr_ctrl #(
      .NIRQ (NIRQ),
      .IDW  (IDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_din   (mask_din),
      .ie_set     (ie_set),
      .ie_clr     (ie_clr),
      .int_ack    (int_ack),
      .reti       (reti),
      .int_req    (int_req),
      .int_id     (int_id),
      .ie         (ie),
      .pending    (pending),
      .mask       (mask),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".int_req"}, 32'(int_req), 32'd0);
      check_eq({tag, ".int_id"}, 32'(int_id), 32'd0);
      check_eq({tag, ".ie"}, 32'(ie), 32'd0);
      check_eq({tag, ".pending"}, 32'(pending), 32'd0);
      check_eq({tag, ".mask"}, 32'(mask), 32'd0);
      check_eq({tag, ".in_service"}, 32'(in_service), 32'd0);
   endtask

   task automatic write_mask(input logic [NIRQ-1:0] m);
      mask_we = 1'b1; mask_din = m;
      step();
      mask_we = 1'b0;
   endtask

   initial begin
      // 1. Reset with arbitrary activity on the inputs.
      irq_in = 4'hf; mask_we = 1'b1; mask_din = 4'hf; ie_set = 1'b1; int_ack = 1'b1; reti = 1'b1;
      step(); step(); step();
      check_all_zero("rst_hold");
      irq_in = '0; mask_we = 1'b0; mask_din = '0; ie_set = 1'b0; int_ack = 1'b0; reti = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check_eq("idle_no_req", 32'(int_req), 32'd0);
      end

      // 2. Basic flow.
      ie_set = 1'b1; write_mask(4'hf); ie_set = 1'b0;
      check_eq("basic.ie", 32'(ie), 32'd1);
      check_eq("basic.mask", 32'(mask), 32'hf);
      irq_in = 4'b0100; step(); irq_in = '0;
      check_eq("basic.pending", 32'(pending), 32'h4);
      check_eq("basic.req_early", 32'(int_req), 32'd0);
      step();
      check_eq("basic.req", 32'(int_req), 32'd1);
      check_eq("basic.id", 32'(int_id), 32'd2);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check_eq("basic.ack_req", 32'(int_req), 32'd0);
      check_eq("basic.ack_pend", 32'(pending), 32'd0);
      check_eq("basic.ack_ie", 32'(ie), 32'd0);
      check_eq("basic.ack_svc", 32'(in_service), 32'd1);
      step();
      check_eq("basic.svc_hold", 32'(in_service), 32'd1);
      reti = 1'b1; step(); reti = 1'b0;
      check_eq("basic.reti_ie", 32'(ie), 32'd1);
      check_eq("basic.reti_svc", 32'(in_service), 32'd0);
      check_eq("basic.id_kept", 32'(int_id), 32'd2);
      step();
      check_eq("basic.quiet", 32'(int_req), 32'd0);

      // 3. Priority between simultaneous edges.
      irq_in = 4'b1010; step(); irq_in = '0;
      check_eq("prio.pending", 32'(pending), 32'ha);
      step();
      check_eq("prio.req1", 32'(int_req), 32'd1);
      check_eq("prio.id1", 32'(int_id), 32'd1);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check_eq("prio.pend_after1", 32'(pending), 32'h8);
      step();
      check_eq("prio.no_req_in_svc", 32'(int_req), 32'd0);
      reti = 1'b1; step(); reti = 1'b0;
      check_eq("prio.idle_req", 32'(int_req), 32'd0);
      step();
      check_eq("prio.req3", 32'(int_req), 32'd1);
      check_eq("prio.id3", 32'(int_id), 32'd3);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      reti = 1'b1; step(); reti = 1'b0;
      check_eq("prio.pend_end", 32'(pending), 32'd0);

      // 4. Masking, then IE gating.
      write_mask(4'b0111);
      irq_in = 4'b1000; step(); irq_in = '0;
      step(); step();
      check_eq("mask.pending", 32'(pending), 32'h8);
      check_eq("mask.no_req", 32'(int_req), 32'd0);
      write_mask(4'hf);
      check_eq("mask.req_not_yet", 32'(int_req), 32'd0);
      step();
      check_eq("mask.req", 32'(int_req), 32'd1);
      check_eq("mask.id", 32'(int_id), 32'd3);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      reti = 1'b1; step(); reti = 1'b0;
      ie_clr = 1'b1; step(); ie_clr = 1'b0;
      check_eq("ie.cleared", 32'(ie), 32'd0);
      irq_in = 4'b0001; step(); irq_in = '0;
      step(); step();
      check_eq("ie.pending", 32'(pending), 32'h1);
      check_eq("ie.no_req", 32'(int_req), 32'd0);
      ie_set = 1'b1; step(); ie_set = 1'b0;
      check_eq("ie.set", 32'(ie), 32'd1);
      check_eq("ie.req_not_yet", 32'(int_req), 32'd0);
      step();
      check_eq("ie.req", 32'(int_req), 32'd1);
      check_eq("ie.id", 32'(int_id), 32'd0);

      // 5. Simultaneous events: new edge on the acknowledged source.
      int_ack = 1'b1; irq_in = 4'b0001; step(); int_ack = 1'b0; irq_in = '0;
      check_eq("sim.set_wins", 32'(pending), 32'h1);
      check_eq("sim.svc", 32'(in_service), 32'd1);
      reti = 1'b1; step(); reti = 1'b0;
      step();
      check_eq("sim.rereq", 32'(int_req), 32'd1);
      check_eq("sim.reid", 32'(int_id), 32'd0);
      // Software ie_set in the ack cycle loses to the hardware clear.
      int_ack = 1'b1; ie_set = 1'b1; step(); int_ack = 1'b0; ie_set = 1'b0;
      check_eq("sim.hw_clr_wins", 32'(ie), 32'd0);
      // Software ie_clr in the reti cycle loses to the hardware set.
      reti = 1'b1; ie_clr = 1'b1; step(); reti = 1'b0; ie_clr = 1'b0;
      check_eq("sim.hw_set_wins", 32'(ie), 32'd1);
      ie_set = 1'b1; ie_clr = 1'b1; step(); ie_set = 1'b0; ie_clr = 1'b0;
      check_eq("sim.clr_wins", 32'(ie), 32'd0);
      // Level held high yields a single event.
      irq_in = 4'b0100;
      for (int i = 0; i < 10; i++) step();
      check_eq("sim.level_pend", 32'(pending), 32'h4);
      ie_set = 1'b1; step(); ie_set = 1'b0;
      step();
      check_eq("sim.level_req", 32'(int_req), 32'd1);
      check_eq("sim.level_id", 32'(int_id), 32'd2);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      step(); step();
      check_eq("sim.level_once", 32'(pending), 32'd0);
      irq_in = '0;
      reti = 1'b1; step(); reti = 1'b0;
      step(); step();
      check_eq("sim.level_no_req", 32'(int_req), 32'd0);

      // 6. Reset while in REQ.
      irq_in = 4'b0001; step(); irq_in = '0;
      step();
      check_eq("rstreq.req", 32'(int_req), 32'd1);
      rst = 1'b0; #1;
      check_all_zero("rstreq");
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check_eq("rstreq.no_req", 32'(int_req), 32'd0);
      check_eq("rstreq.no_pend", 32'(pending), 32'd0);

      // Reset while in SERVICE, with irq_in high across release.
      ie_set = 1'b1; write_mask(4'hf); ie_set = 1'b0;
      irq_in = 4'b0010; step(); irq_in = '0;
      step();
      check_eq("rstsvc.id", 32'(int_id), 32'd1);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      check_eq("rstsvc.svc", 32'(in_service), 32'd1);
      rst = 1'b0; #1;
      check_all_zero("rstsvc");
      irq_in = 4'b0010;
      step(); step();
      check_eq("rstsvc.held_pend", 32'(pending), 32'd0);
      rst = 1'b1;
      step();
      check_eq("rstsvc.edge_pend", 32'(pending), 32'h2);
      step();
      check_eq("rstsvc.masked", 32'(int_req), 32'd0);
      irq_in = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
